// File: rtl/ber_pkg.sv
// Shared state encoding and constants for the BER test controller.
package ber_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESYNC  = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_MEASURE = 3'd3,
        ST_DONE    = 3'd4
    } ber_state_e;

    // Number of cycles the checker is held in reset on every (re)synchronisation.
    localparam int unsigned RESYNC_CYCLES = 2;

    // Width of the lock-loss event counter.
    localparam int unsigned RESYNC_CNT_W  = 8;

    // Width of the resync dwell timer; large enough to hold RESYNC_CYCLES-1.
    localparam int unsigned RS_TMR_W      = 2;

    // True in the states that make up an active test.
    function automatic logic state_is_busy(input ber_state_e s);
        return (s == ST_RESYNC) || (s == ST_ACQUIRE) || (s == ST_MEASURE);
    endfunction

    // True in the states where the checker should be running.
    function automatic logic state_chk_on(input ber_state_e s);
        return (s == ST_ACQUIRE) || (s == ST_MEASURE);
    endfunction

endpackage

// File: rtl/ber_ctrl_sat_acc.sv
// Saturating accumulator: adds inc_i when en_i, clamps at all-ones, clr_i wins.
module sat_acc #(
    parameter int unsigned W  = 8,
    parameter int unsigned IW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [IW-1:0] inc_i,
    output logic [W-1:0]  acc_o
);

    // One spare bit so the carry out of the add is visible.
    localparam int unsigned SW = ((W > IW) ? W : IW) + 1;
    localparam logic [SW-1:0] MAX_VAL = (SW'(1) << W) - SW'(1);

    logic [W-1:0]  acc_q;
    logic [W-1:0]  acc_d;
    logic [SW-1:0] sum;

    // Next value: clear, saturating add, or hold.
    always_comb begin
        acc_d = acc_q;
        sum   = SW'(acc_q) + SW'(inc_i);
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = (sum > MAX_VAL) ? '1 : W'(sum);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ber_ctrl.sv
// BER test controller: resyncs the checker, waits for lock, then counts words
// and bit errors over a programmed window.
module ber_ctrl
    import ber_pkg::*;
#(
    parameter int unsigned WIN_W = 32,
    parameter int unsigned ERR_W = 32,
    parameter int unsigned TO_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [WIN_W-1:0]        win_len,
    input  logic [TO_W-1:0]         lock_to,
    input  logic                    chk_lock,
    input  logic [3:0]              chk_err_num,
    output logic                    chk_en,
    output logic                    chk_reset,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [WIN_W-1:0]        word_cnt,
    output logic [ERR_W-1:0]        err_cnt,
    output logic [RESYNC_CNT_W-1:0] resync_cnt
);

    ber_state_e          state_q,     state_d;
    logic [RS_TMR_W-1:0] rs_tmr_q,    rs_tmr_d;
    logic [TO_W-1:0]     to_cnt_q,    to_cnt_d;
    logic [WIN_W-1:0]    win_len_q,   win_len_d;
    logic [TO_W-1:0]     lock_to_q,   lock_to_d;
    logic [WIN_W-1:0]    word_q,      word_d;
    logic                timeout_q,   timeout_d;
    logic                chk_en_q,    chk_en_d;
    logic                chk_reset_q, chk_reset_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;

    logic                start_ok;
    logic                acc_clr;
    logic                err_en;
    logic                rsc_en;

    // Next-state, counter updates and registered-output decode.
    always_comb begin
        state_d   = state_q;
        rs_tmr_d  = rs_tmr_q;
        to_cnt_d  = to_cnt_q;
        win_len_d = win_len_q;
        lock_to_d = lock_to_q;
        word_d    = word_q;
        timeout_d = timeout_q;
        start_ok  = 1'b0;
        acc_clr   = 1'b0;
        err_en    = 1'b0;
        rsc_en    = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            // Abort beats everything else and leaves the counters untouched.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    start_ok = start;
                end
                ST_RESYNC: begin
                    if (rs_tmr_q == RS_TMR_W'(RESYNC_CYCLES - 1)) begin
                        state_d  = ST_ACQUIRE;
                        rs_tmr_d = '0;
                        to_cnt_d = '0;
                    end else begin
                        rs_tmr_d = rs_tmr_q + RS_TMR_W'(1);
                    end
                end
                ST_ACQUIRE: begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (chk_lock) begin
                        state_d = ST_MEASURE;
                    end else if ((lock_to_q != '0) &&
                                 ((to_cnt_q + TO_W'(1)) == lock_to_q)) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (chk_lock) begin
                        word_d = word_q + WIN_W'(1);
                        err_en = 1'b1;
                        if ((win_len_q == '0) || ((word_q + WIN_W'(1)) == win_len_q)) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        // Lost lock: drop this word and resynchronise the checker.
                        rsc_en   = 1'b1;
                        state_d  = ST_RESYNC;
                        rs_tmr_d = '0;
                    end
                end
                ST_DONE: begin
                    start_ok = start;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (start_ok) begin
                state_d   = ST_RESYNC;
                rs_tmr_d  = '0;
                to_cnt_d  = '0;
                win_len_d = win_len;
                lock_to_d = lock_to;
                word_d    = '0;
                timeout_d = 1'b0;
                acc_clr   = 1'b1;
            end
        end

        // Outputs follow the state being entered so they are registered yet
        // line up with the state they describe.
        chk_en_d    = state_chk_on(state_d);
        chk_reset_d = (state_d == ST_RESYNC);
        busy_d      = state_is_busy(state_d);
        done_d      = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // State, configuration and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rs_tmr_q    <= '0;
            to_cnt_q    <= '0;
            win_len_q   <= '0;
            lock_to_q   <= '0;
            word_q      <= '0;
            timeout_q   <= 1'b0;
            chk_en_q    <= 1'b0;
            chk_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs_tmr_q    <= rs_tmr_d;
            to_cnt_q    <= to_cnt_d;
            win_len_q   <= win_len_d;
            lock_to_q   <= lock_to_d;
            word_q      <= word_d;
            timeout_q   <= timeout_d;
            chk_en_q    <= chk_en_d;
            chk_reset_q <= chk_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Accumulated bit errors over counted words.
    sat_acc #(
        .W  (ERR_W),
        .IW (4)
    ) u_err_acc (
        .clk   (clk),
        .rst_n (reset_n),
        .clr_i (acc_clr),
        .en_i  (err_en),
        .inc_i (chk_err_num),
        .acc_o (err_cnt)
    );

    // Lock-loss events.
    sat_acc #(
        .W  (RESYNC_CNT_W),
        .IW (1)
    ) u_rsc_acc (
        .clk   (clk),
        .rst_n (reset_n),
        .clr_i (acc_clr),
        .en_i  (rsc_en),
        .inc_i (1'b1),
        .acc_o (resync_cnt)
    );

    assign chk_en    = chk_en_q;
    assign chk_reset = chk_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign word_cnt  = word_q;

endmodule

// File: tb/tb_ber_ctrl.sv
// Scoreboard bench for ber_ctrl: a scripted checker model drives lock/errors,
// expected end-of-test results are queued and compared when done pulses.
module tb_ber_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] win_len = '0;
    logic [15:0] lock_to = '0;
    logic        chk_lock = 1'b0;
    logic [3:0]  chk_err_num = '0;

    logic        chk_en, chk_reset, busy, done, timeout;
    logic [31:0] word_cnt, err_cnt;
    logic [7:0]  resync_cnt;

    logic        chk_en4, chk_reset4, busy4, done4, timeout4;
    logic [31:0] word_cnt4;
    logic [3:0]  err_cnt4;
    logic [7:0]  resync_cnt4;

    always #5 clk = ~clk;

    ber_ctrl #(.WIN_W(32), .ERR_W(32), .TO_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .win_len(win_len), .lock_to(lock_to), .chk_lock(chk_lock),
        .chk_err_num(chk_err_num), .chk_en(chk_en), .chk_reset(chk_reset),
        .busy(busy), .done(done), .timeout(timeout), .word_cnt(word_cnt),
        .err_cnt(err_cnt), .resync_cnt(resync_cnt)
    );

    // Narrow error counter instance sharing the same stimulus, for saturation.
    ber_ctrl #(.WIN_W(32), .ERR_W(4), .TO_W(16)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .win_len(win_len), .lock_to(lock_to), .chk_lock(chk_lock),
        .chk_err_num(chk_err_num), .chk_en(chk_en4), .chk_reset(chk_reset4),
        .busy(busy4), .done(done4), .timeout(timeout4), .word_cnt(word_cnt4),
        .err_cnt(err_cnt4), .resync_cnt(resync_cnt4)
    );

    typedef struct {
        logic [31:0] words;
        logic [31:0] err;
        logic [3:0]  err4;
        logic [7:0]  rsc;
        logic        tmo;
        int          run;   // expected chk_en high-run ending at done, -1 = skip
    } exp_t;

    exp_t done_q[$];
    exp_t snap_q[$];
    int   err_seq[$];

    logic snap_req  = 1'b0;
    logic final_req = 1'b0;

    int vectors    = 0;
    int miscompares = 0;
    int en_run     = 0;
    int last_run   = 0;
    int rs_run     = 0;
    exp_t mon_e;

    task automatic cmp(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops expectations when the DUT signals done or a snapshot is due.
    always @(negedge clk) begin
        if (!reset_n) begin
            en_run = 0;
            rs_run = 0;
        end else begin
            if (chk_en) begin
                en_run++;
            end else begin
                if (en_run != 0) last_run = en_run;
                en_run = 0;
            end
            if (chk_reset) begin
                rs_run++;
            end else begin
                if (rs_run != 0) cmp("chk_reset_len", rs_run, 2);
                rs_run = 0;
            end
        end

        if (reset_n && done) begin
            if (done_q.size() == 0) begin
                cmp("unexpected_done", 1, 0);
            end else begin
                mon_e = done_q.pop_front();
                cmp("done_word_cnt", word_cnt, mon_e.words);
                cmp("done_err_cnt", err_cnt, mon_e.err);
                cmp("done_err_cnt_w4", err_cnt4, mon_e.err4);
                cmp("done_resync_cnt", resync_cnt, mon_e.rsc);
                cmp("done_timeout", timeout, mon_e.tmo);
                cmp("done_busy", busy, 0);
                if (mon_e.run >= 0) cmp("chk_en_cycles", last_run, mon_e.run);
            end
        end

        if (snap_req) begin
            if (snap_q.size() == 0) begin
                cmp("snap_missing", 1, 0);
            end else begin
                mon_e = snap_q.pop_front();
                cmp("snap_word_cnt", word_cnt, mon_e.words);
                cmp("snap_err_cnt", err_cnt, mon_e.err);
                cmp("snap_err_cnt_w4", err_cnt4, mon_e.err4);
                cmp("snap_resync_cnt", resync_cnt, mon_e.rsc);
                cmp("snap_timeout", timeout, mon_e.tmo);
                cmp("snap_busy", busy, 0);
                cmp("snap_done", done, 0);
                cmp("snap_chk_en", chk_en, 0);
                cmp("snap_chk_reset", chk_reset, 0);
            end
        end

        if (final_req) cmp("pending_done", done_q.size(), 0);
    end

    // Reference: totals over the first n words of err_seq, with saturation.
    function automatic exp_t expect_words(input int n, input int drops, input int run);
        exp_t e;
        longint sum = 0;
        for (int i = 0; i < n; i++) sum += longint'(err_seq[i]);
        e.words = 32'(n);
        e.err   = (sum > 64'sd4294967295) ? 32'hFFFF_FFFF : 32'(sum);
        e.err4  = (sum > 15) ? 4'hF : 4'(sum);
        e.rsc   = 8'(drops);
        e.tmo   = 1'b0;
        e.run   = run;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_errs(input int n, input int val);
        err_seq.delete();
        for (int i = 0; i < n; i++) err_seq.push_back((val < 0) ? int'($urandom_range(0, 15)) : val);
    endtask

    task automatic wait_en();
        int n = 0;
        while (!chk_en) begin
            tick();
            n++;
            if (n > 50) begin
                $display("FAIL wait_chk_en: still low after %0d cycles, expected high within 50", n);
                $fatal(1, "checker enable never arrived");
            end
        end
    endtask

    // Checker model: lock after 'delay' ACQUIRE cycles, one drop at drop_at,
    // optional ignored start during MEASURE, optional abort on word abort_at.
    task automatic run_test(input int unsigned win, input int unsigned lto, input int delay,
                            input int drop_at, input int redelay,
                            input int bstart_at, input int abort_at);
        int n = (win == 0) ? 1 : int'(win);
        int drops = ((drop_at >= 0) && (drop_at < n)) ? 1 : 0;
        if (abort_at < 0) done_q.push_back(expect_words(n, drops, (drops != 0) ? -1 : delay + 1 + n));
        win_len = win;
        lock_to = 16'(lto);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        win_len = $urandom;
        lock_to = 16'($urandom);
        chk_lock = 1'b0;
        wait_en();
        repeat (delay) begin
            chk_err_num = 4'($urandom_range(0, 15));
            tick();
        end
        chk_lock = 1'b1;
        tick();
        for (int k = 0; k < n; k++) begin
            if (k == drop_at) begin
                chk_lock    = 1'b0;
                chk_err_num = 4'($urandom_range(1, 15));
                tick();
                wait_en();
                repeat (redelay) tick();
                chk_lock = 1'b1;
                tick();
            end
            chk_err_num = 4'(err_seq[k]);
            chk_lock    = 1'b1;
            if (k == bstart_at) begin
                start   = 1'b1;
                win_len = 32'd3;
                lock_to = 16'd1;
            end
            if (k == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                snap_q.push_back(expect_words(k, drops, -1));
                snap_req = 1'b1;
                tick();
                snap_req = 1'b0;
                break;
            end
            tick();
            start = 1'b0;
        end
        chk_lock    = 1'b0;
        chk_err_num = '0;
        repeat (3) tick();
    endtask

    task automatic run_timeout(input int unsigned lto);
        exp_t e;
        int   n = 0;
        e = expect_words(0, 0, int'(lto));
        e.tmo = 1'b1;
        done_q.push_back(e);
        chk_lock = 1'b0;
        win_len  = 32'd7;
        lock_to  = 16'(lto);
        start    = 1'b1;
        tick();
        start = 1'b0;
        while (!done) begin
            chk_err_num = 4'($urandom_range(0, 15));
            tick();
            n++;
            if (n > int'(lto) + 30) begin
                $display("FAIL wait_timeout_done: none after %0d cycles, expected within %0d", n, lto + 30);
                $fatal(1, "timeout done never arrived");
            end
        end
        repeat (3) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   w, d, l, dr, rd, bs;

        // Reset values.
        fill_errs(0, 0);
        snap_q.push_back(expect_words(0, 0, -1));
        snap_req = 1'b1;
        @(negedge clk);
        #1 snap_req = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Normal run: 100 words, lock 5 cycles into ACQUIRE, no errors.
        fill_errs(100, 0);
        run_test(100, 50, 5, -1, 0, -1, -1);

        // Error accumulation: 3 per word over 10 words.
        fill_errs(10, 3);
        run_test(10, 0, 0, -1, 0, -1, -1);

        // Lock loss at word 40 of 100.
        fill_errs(100, -1);
        run_test(100, 30, 2, 40, 1, -1, -1);

        // Abort while in DONE returns to IDLE with counters held.
        e = expect_words(100, 1, -1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        snap_q.push_back(e);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        repeat (3) tick();

        // Lock timeout after 20 ACQUIRE cycles.
        run_timeout(20);

        // Saturation of the narrow counter: 7 per word over 5 words.
        fill_errs(5, 7);
        run_test(5, 0, 1, -1, 0, -1, -1);

        // Zero-length window counts exactly one word.
        fill_errs(4, -1);
        run_test(0, 0, 0, -1, 0, -1, -1);

        // lock_to = 0 disables the timeout even with a long acquisition.
        fill_errs(3, -1);
        run_test(3, 0, 40, -1, 0, -1, -1);

        // Randomised runs with optional lock drop and an ignored start.
        for (int t = 0; t < 6; t++) begin
            w  = int'($urandom_range(1, 40));
            d  = int'($urandom_range(0, 8));
            l  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(12, 22));
            dr = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, w - 1));
            rd = int'($urandom_range(0, 4));
            bs = int'($urandom_range(0, w - 1));
            fill_errs(40, -1);
            run_test(w, l, d, dr, rd, bs, -1);
        end

        // Abort coincident with the final word: no done, word not counted.
        fill_errs(8, -1);
        run_test(8, 0, 1, -1, 0, -1, 7);

        // Reset in the middle of MEASURE clears all outputs at once.
        fill_errs(50, -1);
        win_len = 32'd50;
        lock_to = 16'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        wait_en();
        chk_lock = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk_err_num = 4'(err_seq[k]);
            tick();
        end
        #2 reset_n = 1'b0;
        fill_errs(0, 0);
        snap_q.push_back(expect_words(0, 0, -1));
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk_lock = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Clean run after the reset.
        fill_errs(4, -1);
        run_test(4, 10, 2, -1, 0, -1, -1);

        final_req = 1'b1;
        tick();
        final_req = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
